// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide on magnitudes, one iteration per clock, results on hi/lo at done.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, FINISH} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             is_div, is_div_d;
  logic [WIDTH-1:0] mcand, mcand_d;
  logic [WIDTH:0]   acc, acc_d;
  logic [WIDTH-1:0] mq, mq_d;
  logic             qm1, qm1_d;
  logic [WIDTH-1:0] rem, rem_d;
  logic [WIDTH-1:0] quot, quot_d;
  logic [WIDTH-1:0] dvsr, dvsr_d;
  logic             neg_q, neg_q_d;
  logic             neg_r, neg_r_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d, div_zero_d;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mcand_x;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_tmp;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  // A start landing in the done cycle is dropped even though state is already IDLE.
  assign accept = start && !done && ((op == OP_MULT) || (op == OP_DIV));

  assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  // Accumulator carries one guard bit so the most negative multiplicand cannot overflow.
  assign mcand_x = {mcand[WIDTH-1], mcand};

  always_comb begin
    booth_sum = acc;
    case ({mq[0], qm1})
      2'b01:   booth_sum = acc + mcand_x;
      2'b10:   booth_sum = acc - mcand_x;
      default: booth_sum = acc;
    endcase
  end

  // Trial subtract; when it would go negative the shifted remainder is kept.
  assign div_tmp = {rem, quot[WIDTH-1]};
  assign div_ge  = (div_tmp >= {1'b0, dvsr});
  assign div_rem = div_ge ? (div_tmp[WIDTH-1:0] - dvsr) : div_tmp[WIDTH-1:0];

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    is_div_d   = is_div;
    mcand_d    = mcand;
    acc_d      = acc;
    mq_d       = mq;
    qm1_d      = qm1;
    rem_d      = rem;
    quot_d     = quot;
    dvsr_d     = dvsr;
    neg_q_d    = neg_q;
    neg_r_d    = neg_r;
    hi_d       = hi;
    lo_d       = lo;
    busy_d     = busy;
    done_d     = 1'b0;
    div_zero_d = div_zero;

    case (state)
      IDLE: begin
        if (accept) begin
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          cnt_d      = '0;
          is_div_d   = (op == OP_DIV);
          mcand_d    = a;
          acc_d      = '0;
          mq_d       = b;
          qm1_d      = 1'b0;
          rem_d      = '0;
          quot_d     = a_mag;
          dvsr_d     = b_mag;
          neg_q_d    = a[WIDTH-1] ^ b[WIDTH-1];
          neg_r_d    = a[WIDTH-1];
          state_d    = (op == OP_DIV) ? DIV_RUN : MULT_RUN;
        end
      end

      MULT_RUN: begin
        if (cnt == CW'(WIDTH)) begin
          state_d = FINISH;
        end else begin
          acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          mq_d  = {booth_sum[0], mq[WIDTH-1:1]};
          qm1_d = mq[0];
          cnt_d = cnt + CW'(1);
        end
      end

      DIV_RUN: begin
        if (dvsr == '0) begin
          div_zero_d = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else if (cnt == CW'(WIDTH)) begin
          state_d = FINISH;
        end else begin
          rem_d  = div_rem;
          quot_d = {quot[WIDTH-2:0], div_ge};
          cnt_d  = cnt + CW'(1);
        end
      end

      FINISH: begin
        if (is_div) begin
          lo_d = neg_q ? (~quot + WIDTH'(1)) : quot;
          hi_d = neg_r ? (~rem + WIDTH'(1)) : rem;
        end else begin
          lo_d = mq;
          hi_d = acc[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      mq       <= '0;
      qm1      <= 1'b0;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      is_div   <= is_div_d;
      mcand    <= mcand_d;
      acc      <= acc_d;
      mq       <= mq_d;
      qm1      <= qm1_d;
      rem      <= rem_d;
      quot     <= quot_d;
      dvsr     <= dvsr_d;
      neg_q    <= neg_q_d;
      neg_r    <= neg_r_d;
      hi       <= hi_d;
      lo       <= lo_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected results are queued at issue time
// from a plain-arithmetic model and popped by a monitor on every done pulse.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
    int          blen;
  } exp_t;

  exp_t        scb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          busy_run = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        n_done++;
        if (scb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_done: done seen with no pending operation (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = scb.pop_front();
          chk("hi", {32'h0, hi}, {32'h0, e.hi});
          chk("lo", {32'h0, lo}, {32'h0, e.lo});
          chk("div_zero", {63'h0, div_zero}, {63'h0, e.dz});
          chk("latency", 64'(cyc), 64'(e.due));
          chk("busy_len", 64'(busy_run), 64'(e.blen));
          chk("busy_at_done", {63'h0, busy}, 64'h0);
        end
        busy_run = 0;
      end
    end
  end

  // Reference model: signed product, truncating division, sticky hi/lo on divide by zero.
  task automatic push_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int e0);
    exp_t        e;
    logic [63:0] p;
    int          sx, sy;
    if (o == OP_MULT) begin
      p    = longint'($signed(x)) * longint'($signed(y));
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
      e.blen = 34;
    end else if (y == 32'h0) begin
      e.hi = model_hi;
      e.lo = model_lo;
      e.dz = 1'b1;
      e.blen = 1;
    end else begin
      sx = $signed(x);
      sy = $signed(y);
      if (x == 32'h8000_0000 && sy == -1) begin
        e.lo = 32'h8000_0000;
        e.hi = 32'h0;
      end else begin
        e.lo = 32'(sx / sy);
        e.hi = 32'(sx % sy);
      end
      e.dz = 1'b0;
      e.blen = 34;
    end
    e.due = e0 + e.blen;
    model_hi = e.hi;
    model_lo = e.lo;
    scb.push_back(e);
  endtask

  // Returns at the negedge following the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    if (push) push_exp(o, x, y, cyc);
  endtask

  // Drain the scoreboard while scrambling operands that must be ignored.
  task automatic wait_idle();
    int k = 0;
    while (scb.size() > 0 && k < 200) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      k++;
    end
    chk("drain_timeout", 64'(scb.size()), 64'h0);
    if (scb.size() != 0) scb.delete();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   n0;
    bit   seen;
    vecs[0] = '{OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD};
    vecs[1] = '{OP_MULT, 32'h8000_0000, 32'h8000_0000};
    vecs[2] = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002};
    vecs[3] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF};

    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_div_zero", {63'h0, div_zero}, 64'h0);
    reset = 1'b1;

    // Load nonzero hi/lo, then abort a multiply with reset.
    issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_idle();
    issue(OP_MULT, 32'h7, 32'h5, 1'b0);
    repeat (9) @(negedge clk);
    n0 = n_done;
    reset = 1'b0;
    #1;
    chk("abort_hi", {32'h0, hi}, 64'h0);
    chk("abort_lo", {32'h0, lo}, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(n_done), 64'(n0));

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].x, vecs[i].y, 1'b1);
      wait_idle();
    end

    // Preload hi/lo = 0x11/0x22 via 0x451 / 0x20, then divide by zero.
    issue(OP_DIV, 32'h451, 32'h20, 1'b1);
    wait_idle();
    issue(OP_DIV, 32'h5, 32'h0, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("dz_hold", {63'h0, div_zero}, 64'h1);
    issue(OP_MULT, 32'h3, 32'h4, 1'b1);
    chk("dz_clear", {63'h0, div_zero}, 64'h0);
    wait_idle();

    // Start during a run must not disturb the running multiply.
    issue(OP_MULT, 32'h0001_2345, 32'hFFFF_0001, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start presented in the done cycle is dropped.
    issue(OP_MULT, 32'hFFFF_FFF0, 32'h0000_0010, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", {63'h0, seen}, 64'h1);
    start = 1'b1; op = OP_MULT; a = 32'h3; b = 32'h3;
    @(negedge clk);
    start = 1'b0;
    n0 = n_done;
    repeat (40) @(negedge clk);
    chk("done_cycle_start_ignored", 64'(n_done), 64'(n0));
    if (scb.size() != 0) scb.delete();

    // No-op selects in IDLE.
    for (int k = 0; k < 2; k++) begin
      n0 = n_done;
      issue((k == 0) ? 2'b00 : 2'b11, 32'h9, 32'h3, 1'b0);
      repeat (3) @(negedge clk);
      chk("noop_busy", {63'h0, busy}, 64'h0);
      chk("noop_no_done", 64'(n_done), 64'(n0));
    end

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        n0 = n_done;
        issue((($urandom_range(0, 1)) == 0) ? 2'b00 : 2'b11, $urandom, $urandom, 1'b0);
        repeat (3) @(negedge clk);
        chk("rnd_noop", 64'(n_done), 64'(n0));
      end else begin
        issue(($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV, rnd_val(), rnd_val(), 1'b1);
        wait_idle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
